// File: rtl/mem_sram_responder_pkg.sv
// mem_resp_pkg: shared sizes and the response-stage record for mem_sram_responder.
package mem_resp_pkg;
    localparam int ADDRESS_SIZE = 64;
    localparam int DATA_WIDTH   = 64;
    localparam int NUM_WORDS    = 1024;
    localparam int BE_WIDTH     = DATA_WIDTH / 8;
    localparam int RESP_LATENCY = 2;
    localparam int RESP_MAX_OUT = 2;
    localparam int OFFSET_BITS  = $clog2(BE_WIDTH);
    localparam int INDEX_BITS   = $clog2(NUM_WORDS);

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
    } resp_stage_t;
endpackage

// File: rtl/mem_sram_responder_if.sv
// mem_sram_responder_if: req/gnt/rvalid memory bus between the LSU/fetch master and the SRAM responder.
interface mem_sram_responder_if;
    import mem_resp_pkg::*;
    logic [ADDRESS_SIZE-1:0] address_i;
    logic [DATA_WIDTH-1:0]   data_wdata_i;
    logic                    data_req_i;
    logic                    data_we_i;
    logic [BE_WIDTH-1:0]     data_be_i;
    logic                    data_gnt_o;
    logic                    data_rvalid_o;
    logic [DATA_WIDTH-1:0]   data_rdata_o;

    modport master (
        output address_i, data_wdata_i, data_req_i, data_we_i, data_be_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o
    );
    modport slave (
        input  address_i, data_wdata_i, data_req_i, data_we_i, data_be_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o
    );
endinterface

// File: rtl/mem_sram_array.sv
// mem_sram_array: single-port byte-enabled SRAM; its read register doubles as response stage 0 data.
module mem_sram_array
    import mem_resp_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [INDEX_BITS-1:0] i_index,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [BE_WIDTH-1:0]   i_be,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];

    always_ff @(posedge clk_i) begin
        if (i_we)
            for (int b = 0; b < BE_WIDTH; b++)
                if (i_be[b]) r_mem[i_index][b*8 +: 8] <= i_wdata[b*8 +: 8];
    end

    // Acknowledged writes load zero so their response carries rdata=0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) o_rdata <= '0;
        else if (i_re) o_rdata <= i_we ? '0 : r_mem[i_index];
    end
endmodule

// File: rtl/mem_sram_responder.sv
// mem_sram_responder: fixed-latency in-order SRAM slave with an outstanding-request limit.
// Define MEM_WR_ACK_EN to make writes produce a zero-data rvalid and count toward inflight.
module mem_sram_responder
    import mem_resp_pkg::*;
#(
    parameter  int LATENCY         = RESP_LATENCY,
    parameter  int MAX_OUTSTANDING = RESP_MAX_OUT,
    localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      stall_i,
    mem_sram_responder_if.slave       bus,
    output logic [CW-1:0]             inflight_o
);
`ifdef MEM_WR_ACK_EN
    localparam logic WR_ACK = 1'b1;
`else
    localparam logic WR_ACK = 1'b0;
`endif

    logic                  w_gnt;
    logic                  w_resp;
    logic                  w_rvalid;
    logic                  w_unused;
    logic                  r_v0;
    logic [CW-1:0]         r_inflight;
    logic [DATA_WIDTH-1:0] w_rdata;
    resp_stage_t           w_stage [LATENCY];

    assign w_gnt    = rst_ni & bus.data_req_i & ~stall_i & (r_inflight < CW'(MAX_OUTSTANDING));
    assign w_resp   = w_gnt & (~bus.data_we_i | WR_ACK);
    assign w_rvalid = w_stage[LATENCY-1].valid;
    assign w_unused = ^{bus.address_i[ADDRESS_SIZE-1:OFFSET_BITS+INDEX_BITS], bus.address_i[OFFSET_BITS-1:0]};

    assign bus.data_gnt_o    = w_gnt;
    assign bus.data_rvalid_o = w_rvalid;
    assign bus.data_rdata_o  = w_stage[LATENCY-1].data;
    assign inflight_o        = r_inflight;

    mem_sram_array u_array (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_we    (w_gnt & bus.data_we_i),
        .i_re    (w_resp),
        .i_index (bus.address_i[OFFSET_BITS +: INDEX_BITS]),
        .i_wdata (bus.data_wdata_i),
        .i_be    (bus.data_be_i),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_v0       <= 1'b0;
            r_inflight <= '0;
        end else begin
            r_v0       <= w_resp;
            r_inflight <= (w_resp & ~w_rvalid) ? r_inflight + 1'b1 :
                          (~w_resp & w_rvalid) ? r_inflight - 1'b1 : r_inflight;
        end
    end

    assign w_stage[0] = '{valid: r_v0, data: w_rdata};

    // Later stages only take data with a valid, so the output holds between responses.
    for (genvar i = 1; i < LATENCY; i++) begin : g_stage
        resp_stage_t r_stage;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) r_stage <= '0;
            else begin
                r_stage.valid <= w_stage[i-1].valid;
                if (w_stage[i-1].valid) r_stage.data <= w_stage[i-1].data;
            end
        end
        assign w_stage[i] = r_stage;
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_inflight <= CW'(MAX_OUTSTANDING));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_rvalid && r_inflight == '0));
endmodule

// File: tb/tb_mem_sram_responder.sv
// tb_mem_sram_responder: directed table, corner sequences and random traffic against a queue-based model.
module tb_mem_sram_responder;
    import mem_resp_pkg::*;
    localparam int L = 2;
    localparam int M = 2;
`ifdef MEM_WR_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif
    localparam logic [63:0] D1 = 64'h1122334455667788;
    localparam logic [63:0] D2 = 64'h11223344FFFFFFFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall = 1'b0;
    logic [1:0] inflight;

    mem_sram_responder_if bus();

    mem_sram_responder #(.LATENCY(L), .MAX_OUTSTANDING(M)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .stall_i    (stall),
        .bus        (bus),
        .inflight_o (inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [63:0] data;
        bit          known;
    } resp_t;

    typedef struct {
        bit          req;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [7:0]  be;
        bit          eg;
        bit          erv;
        logic [63:0] erd;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    resp_t       expq[$];
    logic [63:0] mem_m [NUM_WORDS];
    bit          known_m [NUM_WORDS];
    logic [63:0] last_rd = '0;
    bit          last_known = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // One bus cycle: drive at negedge, compare at negedge+1, then apply the model's view of the grant.
    task automatic step(input bit req, input bit we, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [7:0] be, input bit st, output bit g, output bit rv, output logic [63:0] rd);
        bit eg, erv;
        int idx;
        @(negedge clk);
        bus.data_req_i   = req;
        bus.data_we_i    = we;
        bus.address_i    = addr;
        bus.data_wdata_i = wd;
        bus.data_be_i    = be;
        stall            = st;
        #1;
        g  = bus.data_gnt_o;
        rv = bus.data_rvalid_o;
        rd = bus.data_rdata_o;
        eg = req && !st && rst_n && expq.size() < M;
        check("gnt", g, eg);
        check("inflight", inflight, expq.size());
        erv = expq.size() > 0 && expq[0].due == cyc;
        check("rvalid", rv, erv);
        if (erv) begin
            if (expq[0].known) check("rdata", rd, expq[0].data);
            last_rd    = expq[0].data;
            last_known = expq[0].known;
            void'(expq.pop_front());
        end else if (last_known) check("rdata_hold", rd, last_rd);
        if (eg) begin
            idx = int'((addr >> 3) % NUM_WORDS);
            if (we) begin
                for (int b = 0; b < 8; b++) if (be[b]) mem_m[idx][b*8 +: 8] = wd[b*8 +: 8];
                known_m[idx] = known_m[idx] | (be == 8'hFF);
                if (ACK) expq.push_back('{cyc + L, 64'h0, 1'b1});
            end else expq.push_back('{cyc + L, mem_m[idx], known_m[idx]});
        end
        cyc++;
    endtask

    task automatic idle(output bit rv);
        bit g;
        logic [63:0] rd;
        step(0, 0, '0, '0, '0, 0, g, rv, rd);
    endtask

    task automatic issue(input bit we, input logic [63:0] a, input logic [63:0] wd, input logic [7:0] be,
                         input bit rnd_stall, output int gc);
        bit g, rv;
        logic [63:0] rd;
        gc = -1;
        for (int t = 0; t < 64 && gc < 0; t++) begin
            step(1, we, a, wd, be, rnd_stall && ($urandom_range(3) == 0), g, rv, rd);
            if (g) gc = cyc - 1;
        end
        if (gc < 0) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout addr=%h actual=no_grant expected=grant", a);
        end
    endtask

    task automatic drain();
        bit rv;
        for (int t = 0; t < 20 && expq.size() > 0; t++) idle(rv);
        idle(rv);
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d expected=0", expq.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[$];
        bit          g, rv;
        logic [63:0] rd, a;
        int          gc, nrv, peak, i;
        int          gcs[3];
        logic [63:0] rd_addr[3];
        bus.data_req_i   = 0;
        bus.data_we_i    = 0;
        bus.address_i    = '0;
        bus.data_wdata_i = '0;
        bus.data_be_i    = '0;

        // Reset with a request pending must still refuse grants.
        step(1, 0, 64'h100, '0, '0, 0, g, rv, rd);
        check("reset_gnt", g, 0);
        idle(rv);
        check("reset_rvalid", rv, 0);
        check("reset_inflight", inflight, 0);
        check("reset_rdata", bus.data_rdata_o, 0);
        rst_n = 1'b1;

        tbl.push_back('{1, 1, 64'h100, D1, 8'hFF, 1, 0, 64'h0});
        tbl.push_back('{0, 0, 64'h0, 64'h0, 8'h0, 0, 0, 64'h0});
        tbl.push_back('{0, 0, 64'h0, 64'h0, 8'h0, 0, ACK, 64'h0});
        tbl.push_back('{1, 0, 64'h100, 64'h0, 8'h0, 1, 0, 64'h0});
        tbl.push_back('{0, 0, 64'h0, 64'h0, 8'h0, 0, 0, 64'h0});
        tbl.push_back('{0, 0, 64'h0, 64'h0, 8'h0, 0, 1, D1});
        tbl.push_back('{1, 1, 64'h100, '1, 8'h0F, 1, 0, D1});
        tbl.push_back('{0, 0, 64'h0, 64'h0, 8'h0, 0, 0, D1});
        tbl.push_back('{0, 0, 64'h0, 64'h0, 8'h0, 0, ACK, ACK ? 64'h0 : D1});
        tbl.push_back('{1, 0, 64'h100, 64'h0, 8'h0, 1, 0, ACK ? 64'h0 : D1});
        tbl.push_back('{0, 0, 64'h0, 64'h0, 8'h0, 0, 0, ACK ? 64'h0 : D1});
        tbl.push_back('{0, 0, 64'h0, 64'h0, 8'h0, 0, 1, D2});
        tbl.push_back('{1, 1, 64'h2000, 64'hAB, 8'hFF, 1, 0, D2});
        tbl.push_back('{0, 0, 64'h0, 64'h0, 8'h0, 0, 0, D2});
        tbl.push_back('{0, 0, 64'h0, 64'h0, 8'h0, 0, ACK, ACK ? 64'h0 : D2});
        tbl.push_back('{1, 0, 64'h0, 64'h0, 8'h0, 1, 0, ACK ? 64'h0 : D2});
        tbl.push_back('{0, 0, 64'h0, 64'h0, 8'h0, 0, 0, ACK ? 64'h0 : D2});
        tbl.push_back('{0, 0, 64'h0, 64'h0, 8'h0, 0, 1, 64'hAB});
        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].req, tbl[k].we, tbl[k].addr, tbl[k].wd, tbl[k].be, 0, g, rv, rd);
            check($sformatf("tbl%0d_gnt", k), g, tbl[k].eg);
            check($sformatf("tbl%0d_rvalid", k), rv, tbl[k].erv);
            check($sformatf("tbl%0d_rdata", k), rd, tbl[k].erd);
        end

        // Back-to-back reads: the third must wait for a freed slot.
        issue(1, 64'h8, 64'h0808080808080808, 8'hFF, 0, gc);
        issue(1, 64'h10, 64'h1010101010101010, 8'hFF, 0, gc);
        drain();
        rd_addr = '{64'h0, 64'h8, 64'h10};
        i = 0; nrv = 0; peak = 0;
        for (int t = 0; t < 16 && nrv < 3; t++) begin
            step(i < 3, 0, i < 3 ? rd_addr[i] : 64'h0, '0, '0, 0, g, rv, rd);
            if (g) begin gcs[i] = cyc - 1; i++; end
            if (int'(inflight) > peak) peak = int'(inflight);
            if (rv) nrv++;
        end
        check("b2b_gap01", gcs[1] - gcs[0], 1);
        check("b2b_gap12", gcs[2] - gcs[1], 2);
        check("b2b_peak", peak, 2);
        check("b2b_rvalids", nrv, 3);

        // Stall blocks grants but the earlier read still completes.
        issue(0, 64'h100, '0, '0, 0, gc);
        nrv = 0;
        for (int t = 0; t < 5; t++) begin
            step(1, 0, 64'h8, '0, '0, 1, g, rv, rd);
            check("stall_gnt", g, 0);
            if (rv) nrv++;
        end
        check("stall_rvalids", nrv, 1);
        issue(0, 64'h8, '0, '0, 0, gc);
        drain();

        // Reset with two reads in flight drops both responses.
        issue(0, 64'h0, '0, '0, 0, gc);
        issue(0, 64'h8, '0, '0, 0, gc);
        @(posedge clk);
        #1;
        bus.data_req_i = 0;
        rst_n = 1'b0;
        expq.delete();
        last_rd = '0;
        last_known = 1'b1;
        #1;
        check("midreset_inflight", inflight, 0);
        check("midreset_rvalid", bus.data_rvalid_o, 0);
        idle(rv);
        idle(rv);
        rst_n = 1'b1;
        nrv = 0;
        for (int t = 0; t < 4; t++) begin idle(rv); if (rv) nrv++; end
        check("postreset_rvalids", nrv, 0);
        issue(1, 64'h40, 64'h1234, 8'hFF, 0, gc);
        nrv = 0;
        for (int t = 0; t < 4; t++) begin idle(rv); if (rv) nrv++; end
        check("write_ack_rvalids", nrv, ACK);

        // Random traffic over a pre-written window with random high/offset address bits.
        for (int w = 0; w < 16; w++) issue(1, 64'(w * 8), {$urandom, $urandom}, 8'hFF, 0, gc);
        drain();
        for (int n = 0; n < 300; n++) begin
            a = {$urandom, $urandom};
            a[12:3] = 10'($urandom_range(15));
            issue(1'($urandom_range(1)), a, {$urandom, $urandom}, 8'($urandom), 1, gc);
            for (int t = $urandom_range(2); t > 0; t--) idle(rv);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
